// File: rtl/data_mem_responder.sv
// Word-organised data memory that answers MEM-stage load/store requests.
// Accepts one request at a time, waits WAIT_STATES cycles, then pulses a response.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int         AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rd_q;

  logic        cur_we;
  logic [2:0]  cur_funct3;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [AW-1:0] cur_idx;
  logic        illegal, misaligned, out_of_range, cur_err;
  logic [3:0]  byte_en;
  logic [31:0] lane_wdata;
  logic        accept, enter_resp, mem_we;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero wait states the memory is accessed on the acceptance edge itself,
  // so the live request is used in IDLE and the latched copy everywhere else.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we     = req_we;
      cur_funct3 = req_funct3;
      cur_addr   = req_addr;
      cur_wdata  = req_wdata;
    end else begin
      cur_we     = we_q;
      cur_funct3 = funct3_q;
      cur_addr   = addr_q;
      cur_wdata  = wdata_q;
    end
    cur_idx = cur_addr[AW+1:2];
  end

  always_comb begin
    if (cur_we) begin
      illegal = (cur_funct3 != 3'b000) && (cur_funct3 != 3'b001) && (cur_funct3 != 3'b010);
    end else begin
      illegal = (cur_funct3 == 3'b011) || (cur_funct3 == 3'b110) || (cur_funct3 == 3'b111);
    end
    misaligned   = ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) ||
                   ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
    out_of_range = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    cur_err      = illegal | misaligned | out_of_range;

    byte_en    = 4'b0000;
    lane_wdata = cur_wdata;
    case (cur_funct3[1:0])
      2'b00: begin
        byte_en    = 4'b0001 << cur_addr[1:0];
        lane_wdata = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        byte_en    = cur_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{cur_wdata[15:0]}};
      end
      2'b10: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    accept   = (state_q == IDLE) && req_valid && req_ready_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (WS == 4'd0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WS;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    enter_resp  = (state_d == RESP) && (state_q != RESP);
    mem_we      = enter_resp && cur_we && !cur_err;
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    rsp_err_d   = enter_resp ? cur_err : 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array is never reset; stores commit and loads read on the edge entering RESP.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && byte_en[i]) begin
        mem[cur_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
      end
    end
    if (enter_resp) begin
      rd_q <= mem[cur_idx];
    end
  end

  always_comb begin
    sel_byte  = rd_q[{addr_q[1:0], 3'b000} +: 8];
    sel_half  = rd_q[{addr_q[1], 4'b0000} +: 16];
    load_data = rd_q;
    case (funct3_q)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_data = {24'd0, sel_byte};
      3'b101:  load_data = {16'd0, sel_half};
      default: load_data = rd_q;
    endcase
    rsp_rdata = (rsp_valid_q && !rsp_err_q && !we_q) ? load_data : 32'd0;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

endmodule
